// File: rtl/td4_core.sv
// -----------------------------------------------------------------------------
// td4_core
//   4-bit TD4-class CPU core. It executes one 8-bit instruction per clock.
//   Instructions come combinationally from an external asynchronous ROM that is
//   addressed by ip.
//
//   State: A, B (4-bit), carry C, ip (4-bit), output latch gpo (4-bit).
//
//   Ports:
//     clk    in   1  system clock, rising edge
//     rst_n  in   1  asynchronous active-low reset
//     op     in   8  instruction at address ip; op[7:4] opcode, op[3:0] immediate
//     gpi    in   4  general-purpose input, read by IN A / IN B
//     gpo    out  4  general-purpose output latch, written by OUT B / OUT Im
//     ip     out  4  instruction pointer
//
//   Optional feature, enabled with macro TD4_DEBUG_PORTS_EN:
//     dbg_a  out  4  register A
//     dbg_b  out  4  register B
//     dbg_c  out  1  carry flag
//   With the macro undefined these ports do not exist.
// -----------------------------------------------------------------------------
module td4_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] op,
    input  logic [3:0] gpi,
    output logic [3:0] gpo,
    output logic [3:0] ip
`ifdef TD4_DEBUG_PORTS_EN
    ,
    output logic [3:0] dbg_a,
    output logic [3:0] dbg_b,
    output logic       dbg_c
`endif
);

    // Opcode encodings (op[7:4])
    localparam logic [3:0] OpAddA  = 4'b0000;
    localparam logic [3:0] OpMovAB = 4'b0001;
    localparam logic [3:0] OpInA   = 4'b0010;
    localparam logic [3:0] OpMovAI = 4'b0011;
    localparam logic [3:0] OpMovBA = 4'b0100;
    localparam logic [3:0] OpAddB  = 4'b0101;
    localparam logic [3:0] OpInB   = 4'b0110;
    localparam logic [3:0] OpMovBI = 4'b0111;
    localparam logic [3:0] OpOutB  = 4'b1001;
    localparam logic [3:0] OpOutI  = 4'b1011;
    localparam logic [3:0] OpJnc   = 4'b1110;
    localparam logic [3:0] OpJmp   = 4'b1111;

    logic [3:0] r_a;
    logic [3:0] r_b;
    logic       r_c;
    logic [3:0] r_ip;
    logic [3:0] r_gpo;

    logic [3:0] w_a_d;
    logic [3:0] w_b_d;
    logic       w_c_d;
    logic [3:0] w_ip_d;
    logic [3:0] w_gpo_d;

    logic [3:0] w_imm;
    logic [4:0] w_sum_a;
    logic [4:0] w_sum_b;

    assign w_imm   = op[3:0];
    assign w_sum_a = {1'b0, r_a} + {1'b0, w_imm};
    assign w_sum_b = {1'b0, r_b} + {1'b0, w_imm};

    // Next-state decode. Every instruction rewrites C. Only ADD can set it.
    // Unlisted opcodes, and X/Z on op, go to the default branch and act as NOP.
    always_comb begin
        w_a_d   = r_a;
        w_b_d   = r_b;
        w_c_d   = 1'b0;
        w_ip_d  = r_ip + 4'd1;
        w_gpo_d = r_gpo;
        case (op[7:4])
            OpAddA:  {w_c_d, w_a_d} = w_sum_a;
            OpAddB:  {w_c_d, w_b_d} = w_sum_b;
            OpMovAI: w_a_d = w_imm;
            OpMovBI: w_b_d = w_imm;
            OpMovAB: w_a_d = r_b;
            OpMovBA: w_b_d = r_a;
            OpInA:   w_a_d = gpi;
            OpInB:   w_b_d = gpi;
            OpOutB:  w_gpo_d = r_b;
            OpOutI:  w_gpo_d = w_imm;
            OpJmp:   w_ip_d = w_imm;
            // JNC tests the carry left by the previous instruction.
            OpJnc: begin
                if (!r_c) begin
                    w_ip_d = w_imm;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= 4'd0;
            r_b   <= 4'd0;
            r_c   <= 1'b0;
            r_ip  <= 4'd0;
            r_gpo <= 4'd0;
        end else begin
            r_a   <= w_a_d;
            r_b   <= w_b_d;
            r_c   <= w_c_d;
            r_ip  <= w_ip_d;
            r_gpo <= w_gpo_d;
        end
    end

    assign gpo = r_gpo;
    assign ip  = r_ip;

`ifdef TD4_DEBUG_PORTS_EN
    assign dbg_a = r_a;
    assign dbg_b = r_b;
    assign dbg_c = r_c;
`endif

endmodule

// File: tb/tb_td4_core.sv
// -----------------------------------------------------------------------------
// tb_td4_core
//   Directed-vector bench for td4_core. The bench holds a 16-entry ROM that
//   drives op combinationally from ip. Each program is loaded and then run from
//   reset. Register values are read out through OUT instructions.
// -----------------------------------------------------------------------------
module tb_td4_core;

    logic       clk;
    logic       rst_n;
    logic [7:0] op;
    logic [3:0] gpi;
    logic [3:0] gpo;
    logic [3:0] ip;
`ifdef TD4_DEBUG_PORTS_EN
    logic [3:0] dbg_a;
    logic [3:0] dbg_b;
    logic       dbg_c;
`endif

    logic [7:0] rom [16];

    int n_checks;
    int n_fails;

    td4_core u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .op    (op),
        .gpi   (gpi),
        .gpo   (gpo),
        .ip    (ip)
`ifdef TD4_DEBUG_PORTS_EN
        ,
        .dbg_a (dbg_a),
        .dbg_b (dbg_b),
        .dbg_c (dbg_c)
`endif
    );

    assign op = rom[ip];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit after the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Fill every ROM slot with a NOP (opcode 1000).
    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    endtask

    // Assert reset mid-cycle and check the async clear at once. Hold for 3 edges,
    // then release 1 unit after an edge so the next edge runs ROM[0].
    task automatic reset_dut(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq({tag, "_ip_async"}, {4'h0, ip}, 8'h00);
        check_eq({tag, "_gpo_async"}, {4'h0, gpo}, 8'h00);
        step(3);
        check_eq({tag, "_ip_hold"}, {4'h0, ip}, 8'h00);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b1;
        gpi      = 4'h0;
        clear_rom();

        // Program 1: OUT 7; ADD/JNC loop; carry clearing by NOP.
        rom[0] = 8'hB7;  // OUT 7
        rom[1] = 8'h01;  // ADD A,1
        rom[2] = 8'hE1;  // JNC 1
        rom[3] = 8'h40;  // MOV B,A
        rom[4] = 8'h90;  // OUT B
        rom[5] = 8'h3F;  // MOV A,F
        rom[6] = 8'h01;  // ADD A,1 -> C=1
        rom[7] = 8'h80;  // NOP clears C
        rom[8] = 8'hE0;  // JNC 0 taken
        reset_dut("rst0");
        step(1);
        check_eq("out7_gpo", {4'h0, gpo}, 8'h07);
        check_eq("out7_ip", {4'h0, ip}, 8'h01);
        step(30);  // 15 ADD/JNC pairs, A=15
        check_eq("loop15_ip", {4'h0, ip}, 8'h01);
        step(1);   // 16th ADD wraps A to 0 with C=1
        check_eq("add16_ip", {4'h0, ip}, 8'h02);
        step(1);   // JNC falls through
        check_eq("jnc_fall_ip", {4'h0, ip}, 8'h03);
        step(2);
        check_eq("a_wrap_gpo", {4'h0, gpo}, 8'h00);
        check_eq("a_wrap_ip", {4'h0, ip}, 8'h05);
        step(3);
        check_eq("nop_ip", {4'h0, ip}, 8'h08);
        step(1);
        check_eq("nop_clr_c_jnc", {4'h0, ip}, 8'h00);

        // Program 2: IN, MOV, carry via immediate, IN B, ip wrap.
        clear_rom();
        rom[0]  = 8'h20;  // IN A
        rom[1]  = 8'h40;  // MOV B,A
        rom[2]  = 8'h90;  // OUT B
        rom[3]  = 8'h3F;  // MOV A,F
        rom[4]  = 8'h01;  // ADD A,1 -> A=0 C=1
        rom[5]  = 8'hE9;  // JNC 9 not taken
        rom[6]  = 8'h40;  // MOV B,A
        rom[7]  = 8'h90;  // OUT B
        rom[8]  = 8'h60;  // IN B
        rom[9]  = 8'h90;  // OUT B
        rom[10] = 8'h7C;  // MOV B,C
        rom[11] = 8'h10;  // MOV A,B
        rom[12] = 8'h71;  // MOV B,1
        rom[13] = 8'h40;  // MOV B,A
        rom[14] = 8'h90;  // OUT B
        // rom[15] stays NOP: ip must wrap 15 -> 0
        reset_dut("rst1");
        gpi = 4'h5;
        step(3);
        check_eq("in_a_gpo", {4'h0, gpo}, 8'h05);
        step(3);
        check_eq("carry_jnc_ip", {4'h0, ip}, 8'h06);
        step(2);
        check_eq("a_zero_gpo", {4'h0, gpo}, 8'h00);
        gpi = 4'hA;
        step(2);
        check_eq("in_b_gpo", {4'h0, gpo}, 8'h0A);
        step(5);
        check_eq("mov_chain_gpo", {4'h0, gpo}, 8'h0C);
        check_eq("pre_wrap_ip", {4'h0, ip}, 8'h0F);
        step(1);
        check_eq("wrap_ip", {4'h0, ip}, 8'h00);
        check_eq("wrap_gpo_hold", {4'h0, gpo}, 8'h0C);

        // Program 3: ADD B with carry, JNC after OUT, mid-run reset.
        clear_rom();
        rom[0] = 8'h7C;  // MOV B,C
        rom[1] = 8'h55;  // ADD B,5 -> B=1 C=1
        rom[2] = 8'hE0;  // JNC 0 not taken
        rom[3] = 8'h90;  // OUT B
        rom[4] = 8'h5F;  // ADD B,F -> B=0 C=1
        rom[5] = 8'h90;  // OUT B, C=0
        rom[6] = 8'hE6;  // JNC 6 taken forever
        reset_dut("rst2");
        step(4);
        check_eq("add_b_gpo", {4'h0, gpo}, 8'h01);
        step(2);
        check_eq("add_b_wrap_gpo", {4'h0, gpo}, 8'h00);
        step(3);
        check_eq("jnc_self_ip", {4'h0, ip}, 8'h06);
        rom[3] = 8'hB9;  // mark restart path
        reset_dut("rst_mid");
        step(4);
        check_eq("restart_gpo", {4'h0, gpo}, 8'h09);
        check_eq("restart_ip", {4'h0, ip}, 8'h04);

        // Program 4: timer-style OUT sequence that parks on JMP 15.
        clear_rom();
        rom[0]  = 8'hB7;
        rom[1]  = 8'hB6;
        rom[2]  = 8'hB0;
        rom[3]  = 8'hB4;
        rom[4]  = 8'hB8;
        rom[5]  = 8'hFF;  // JMP 15
        rom[15] = 8'hFF;  // JMP 15
        reset_dut("rst3");
        step(1); check_eq("timer_gpo0", {4'h0, gpo}, 8'h07);
        step(1); check_eq("timer_gpo1", {4'h0, gpo}, 8'h06);
        step(1); check_eq("timer_gpo2", {4'h0, gpo}, 8'h00);
        step(1); check_eq("timer_gpo3", {4'h0, gpo}, 8'h04);
        step(1); check_eq("timer_gpo4", {4'h0, gpo}, 8'h08);
        step(1); check_eq("timer_jmp_ip", {4'h0, ip}, 8'h0F);
        step(20);
        check_eq("timer_park_ip", {4'h0, ip}, 8'h0F);
        check_eq("timer_park_gpo", {4'h0, gpo}, 8'h08);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
